// File: rtl/down_counter_timer_pkg.sv
// Shared constants and state type for the down-counter timer.
package down_counter_timer_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_timer_dec_cell.sv
// WIDTH-bit decrementer with zero detect feeding the timer's count register.
module dec_cell #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] dec,
  output logic             is_zero
);

  assign dec     = value - WIDTH'(1);
  assign is_zero = (value == '0);

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with one-shot or auto-reload expiry and a
// combinational borrow-out pulse.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             reload,
  output logic [WIDTH-1:0] counter,
  output logic             bo,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload_val;
  logic [WIDTH-1:0] count_dec;
  logic             count_zero;

  dec_cell #(.WIDTH(WIDTH)) u_dec (
    .value   (count),
    .dec     (count_dec),
    .is_zero (count_zero)
  );

  // Load beats enable; expiry either re-arms from the captured load value or parks in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      reload_val <= '0;
      state      <= IDLE;
    end else if (ld) begin
      count      <= ld_val;
      reload_val <= ld_val;
      state      <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            if (!count_zero) begin
              count <= count_dec;
            end else if (reload) begin
              count <= reload_val;
            end else begin
              state <= DONE;
            end
          end
        end
        IDLE, DONE: begin
          count <= count;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign counter = count;
  assign zero    = count_zero;
  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign bo      = (state == RUN) & en & ~ld & count_zero;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] ld_val = 4'd0;
  logic       reload = 1'b0;
  logic [3:0] counter;
  logic       bo;
  logic       zero;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  // Behavioural model: count value, remembered period, and two activity flags.
  int m_cnt = 0;
  int m_rl = 0;
  bit m_running = 1'b0;
  bit m_finished = 1'b0;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .ld      (ld),
    .ld_val  (ld_val),
    .reload  (reload),
    .counter (counter),
    .bo      (bo),
    .zero    (zero),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic bit model_bo();
    return m_running && en && !ld && (m_cnt == 0);
  endfunction

  task automatic applyStimulus(input bit r, input bit l, input logic [3:0] lv,
                               input bit e, input bit rm);
    @(negedge clk);
    rst = r; ld = l; ld_val = lv; en = e; reload = rm;
    #1;
  endtask

  // Clock edge plus model update from the inputs held across that edge.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_rl = 0; m_running = 0; m_finished = 0;
    end else if (ld) begin
      m_cnt = ld_val; m_rl = ld_val; m_running = 1; m_finished = 0;
    end else if (m_running && en) begin
      if (m_cnt == 0) begin
        if (reload) m_cnt = m_rl;
        else begin m_running = 0; m_finished = 1; end
      end else begin
        m_cnt = (m_cnt - 1) % 16;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1, 1, 4'd7, 1, 1);
    advance();
    applyStimulus(1, 0, 4'd0, 0, 0);
    advance();
    applyStimulus(0, 0, 4'd0, 0, 0);
    checks++;
    if ({counter, zero, busy, done, bo} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_state: got cnt=%0d z=%b busy=%b done=%b bo=%b expected 0 1 0 0 0",
               counter, zero, busy, done, bo);
    end
    advance();
    applyStimulus(0, 0, 4'd0, 1, 0);
    checks++;
    if (counter !== 4'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_hold: got cnt=%0d busy=%b expected 0 0", counter, busy);
    end
    advance();
  endtask

  task automatic test_one_shot();
    int exp_seq[4] = '{3, 2, 1, 0};
    applyStimulus(0, 1, 4'd3, 0, 0);
    advance();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 4'd0, 1, 0);
      checks++;
      if (counter !== 4'(exp_seq[i]) || bo !== (i == 3) || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL one_shot[%0d]: got cnt=%0d bo=%b busy=%b expected %0d %b 1",
                 i, counter, bo, busy, exp_seq[i], (i == 3));
      end
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 4'd0, 1, 1);
      checks++;
      if ({counter, bo, busy, done, zero} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
        failures++;
        $display("[TB] FAIL one_shot_done[%0d]: got cnt=%0d bo=%b busy=%b done=%b expected 0 0 0 1",
                 i, counter, bo, busy, done);
      end
      advance();
    end
  endtask

  task automatic test_periodic();
    applyStimulus(0, 1, 4'd2, 0, 1);
    advance();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, 4'd0, 1, 1);
      checks++;
      if (counter !== 4'(2 - (i % 3)) || bo !== ((i % 3) == 2) || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL periodic[%0d]: got cnt=%0d bo=%b busy=%b expected %0d %b 1",
                 i, counter, bo, busy, 2 - (i % 3), ((i % 3) == 2));
      end
      advance();
    end
  endtask

  task automatic test_zero_reload();
    applyStimulus(0, 1, 4'd0, 0, 1);
    advance();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 4'd0, 1, 1);
      checks++;
      if (counter !== 4'd0 || bo !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL zero_reload[%0d]: got cnt=%0d bo=%b busy=%b expected 0 1 1",
                 i, counter, bo, busy);
      end
      advance();
    end
  endtask

  task automatic test_enable_gating();
    int exp_seq[4] = '{5, 4, 4, 3};
    applyStimulus(0, 1, 4'd5, 0, 0);
    advance();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 4'd0, (i % 2) == 0, 0);
      checks++;
      if (counter !== 4'(exp_seq[i]) || bo !== 1'b0) begin
        failures++;
        $display("[TB] FAIL enable_gating[%0d]: got cnt=%0d bo=%b expected %0d 0",
                 i, counter, bo, exp_seq[i]);
      end
      advance();
    end
  endtask

  task automatic test_load_over_expiry();
    applyStimulus(0, 1, 4'd1, 0, 0);
    advance();
    applyStimulus(0, 0, 4'd0, 1, 0);
    advance();
    applyStimulus(0, 1, 4'd9, 1, 0);
    checks++;
    if (counter !== 4'd0 || bo !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_over_expiry_bo: got cnt=%0d bo=%b expected 0 0", counter, bo);
    end
    advance();
    applyStimulus(0, 0, 4'd0, 0, 0);
    checks++;
    if (counter !== 4'd9 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_over_expiry_next: got cnt=%0d busy=%b done=%b expected 9 1 0",
               counter, busy, done);
    end
    advance();
  endtask

  task automatic test_reset_priority();
    applyStimulus(0, 1, 4'd6, 0, 1);
    advance();
    applyStimulus(1, 1, 4'($urandom_range(1, 15)), 1, 1);
    advance();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 4'd0, 1, 1);
      checks++;
      if ({counter, zero, busy, done, bo} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("[TB] FAIL reset_priority[%0d]: got cnt=%0d z=%b busy=%b done=%b bo=%b expected 0 1 0 0 0",
                 i, counter, zero, busy, done, bo);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0,
                    4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1);
      checks++;
      if ({counter, zero, busy, done, bo} !==
          {4'(m_cnt), (m_cnt == 0), m_running, m_finished, model_bo()}) begin
        failures++;
        $display("[TB] FAIL random[%0d]: got cnt=%0d z=%b busy=%b done=%b bo=%b expected %0d %b %b %b %b",
                 i, counter, zero, busy, done, bo,
                 m_cnt, (m_cnt == 0), m_running, m_finished, model_bo());
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_zero_reload();
    test_enable_gating();
    test_load_over_expiry();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001: WIDTH, 4, counter width in bits; all count-related ports are WIDTH wide.
REQ-002: clk  input  1  single clock; all state updates on its rising edge.
REQ-003: rst  input  1  reset, synchronous and active-high.
REQ-004: en  input  1  count enable; decrement permitted only when high.
REQ-005: ld  input  1  parallel-load strobe.
REQ-006: ld_val  input  WIDTH  load value, also captured as the reload value.
REQ-007: reload  input  1  1 = periodic (auto-reload) mode, 0 = one-shot mode; sampled at expiry.
REQ-008: counter  output  WIDTH  current count, driven directly from the count register.
REQ-009: bo  output  1  borrow-out: expiry event, combinational.
REQ-010: zero  output  1  combinational, high when counter == 0.
REQ-011: busy  output  1  high in state RUN.
REQ-012: done  output  1  high in state DONE.

Function
REQ-013: States IDLE, RUN, DONE, held in a registered state variable.
REQ-014: ld=1 in any state: counter <= ld_val, reload register <= ld_val, next state RUN, regardless of en.
REQ-015: ld has priority over en; there is no decrement in a load cycle.
REQ-016: IDLE with ld=0: counter and state hold.
REQ-017: RUN, ld=0, en=0: counter and state hold, bo=0.
REQ-018: RUN, ld=0, en=1, counter != 0: counter <= counter - 1, stay in RUN.
REQ-019: bo = (state==RUN) & en & ~ld & (counter==0); bo is asserted only in that cycle and is never registered.
REQ-020: Expiry with reload=1: counter <= reload register, stay in RUN; period is reload value + 1 enabled cycles.
REQ-021: Expiry with reload=0: counter stays 0, next state DONE.
REQ-022: DONE with ld=0: counter holds at 0, bo=0, done=1; en is ignored; the block leaves DONE only on ld or rst.
REQ-023: ld_val=0 in RUN with reload=1: bo is asserted on every enabled cycle.
REQ-024: Decrement is modulo 2^WIDTH arithmetic; underflow below 0 never occurs because expiry (REQ-020/021) handles counter==0.
REQ-025: ld together with a pending expiry: the load wins and bo=0 in that cycle.

Reset
REQ-026: rst=1 at the clock edge: counter=0, reload register=0, state=IDLE; therefore busy=0, done=0, bo=0, zero=1 on the following cycle.
REQ-027: rst has priority over ld and en, including mid-count in RUN and in DONE.
REQ-028: The block has no asynchronous reset path.

Structure
REQ-029: A shared package holds the WIDTH default constant and the state enumeration type (IDLE, RUN, DONE).
REQ-030: A single sub-module, dec_cell, implements the WIDTH-bit decrementer and zero detect; the top level contains the FSM, the reload register and the output logic.
REQ-031: No latches; all outputs other than bo and zero are derived from registers.

Verification
REQ-032: rst=1 for 2 cycles -> counter=0, zero=1, busy=0, done=0, bo=0.
REQ-033: ld_val=3 with ld for 1 cycle, reload=0, then en=1 held -> counter 3,2,1,0; bo=1 for exactly one cycle at counter==0; next cycle done=1, busy=0, counter=0.
REQ-034: ld_val=2 with ld, reload=1, en=1 held for 9 cycles -> counter sequence 2,1,0,2,1,0,2,1,0; bo high on each 0; busy=1 throughout.
REQ-035: Counting from 5 with en toggling 1,0,1,0 -> counter 5,4,4,3; bo=0.
REQ-036: counter=0 in RUN with en=1 and ld=1, ld_val=9 -> bo=0, next counter=9, state RUN.
REQ-037: rst=1 asserted mid-count at counter=6 in RUN, with en=1 and ld=1 in the same cycle -> next cycle counter=0, state IDLE; a subsequent en-only sequence leaves counter at 0.
